// File: rtl/interlacer.sv
// interlacer: progressive-to-interlaced converter.
// Takes progressive frames on an Avalon-ST sink and emits one field per frame on an
// Avalon-ST source. The field alternates even lines, then odd lines, frame by frame.
// Output framing comes from the pixel/line counters. din_endofpacket is only used to
// detect framing errors and to close a frame early.
module interlacer #(
    parameter int DATA_WIDTH  = 24,
    parameter int LINE_WIDTH  = 1024,
    parameter int FRAME_LINES = 576
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  din_startofpacket,
    input  logic                  din_endofpacket,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket,
    output logic                  field_parity,
    output logic                  frame_err
);

    localparam int PIX_W  = $clog2(LINE_WIDTH);
    localparam int LINE_W = $clog2(FRAME_LINES);

    localparam logic [PIX_W-1:0]  PIX_LAST       = PIX_W'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0] LINE_LAST      = LINE_W'(FRAME_LINES - 1);
    localparam logic [LINE_W-1:0] LINE_EVEN_LAST = LINE_W'(FRAME_LINES - 2);

    typedef enum logic [1:0] {
        WAIT_SOP,
        KEEP,
        DROP
    } state_t;

    // Control registers
    state_t              state_q,    state_d;
    logic [PIX_W-1:0]    pix_cnt_q,  pix_cnt_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                parity_q,   parity_d;
    logic                frame_err_q, frame_err_d;

    // Output stage registers
    logic [DATA_WIDTH-1:0] dout_data_q,  dout_data_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_sop_q,   dout_sop_d;
    logic                  dout_eop_q,   dout_eop_d;
    logic                  field_par_q,  field_par_d;

    // Decode of the beat currently offered on the sink
    logic                out_stall;
    logic                in_frame;
    logic                restart;
    logic                eff_par;
    logic [PIX_W-1:0]    eff_pix;
    logic [LINE_W-1:0]   eff_line;
    logic                keep_beat;
    logic                accept;
    logic                at_line_end;
    logic                at_frame_end;
    logic                close_frame;
    logic                err_beat;
    logic                out_sop;
    logic                out_eop;
    logic [PIX_W-1:0]    pix_nxt;
    logic [LINE_W-1:0]   line_nxt;

    // Work out where the offered beat lands in the frame and whether it is kept.
    // A sop seen mid-frame restarts at (0,0) under the flipped parity, so every
    // decision below uses the effective position and parity, not the raw counters.
    // Ready is withheld only when the beat would be kept while the output register
    // is stalled. That keeps dropped lines and discarded pre-sop beats flowing, and it
    // also protects a stalled beat from being overwritten by a keeping sop.
    always_comb begin
        out_stall = dout_valid_q && !dout_ready;
        in_frame  = (state_q != WAIT_SOP) || din_startofpacket;
        restart   = (state_q != WAIT_SOP) && din_startofpacket &&
                    ((pix_cnt_q != '0) || (line_cnt_q != '0));
        eff_par   = restart ? ~parity_q : parity_q;
        if ((state_q == WAIT_SOP) || restart) begin
            eff_pix  = '0;
            eff_line = '0;
        end else begin
            eff_pix  = pix_cnt_q;
            eff_line = line_cnt_q;
        end
        keep_beat    = in_frame && (eff_line[0] == eff_par);
        din_ready    = !(out_stall && keep_beat);
        accept       = din_valid && din_ready;
        at_line_end  = (eff_pix == PIX_LAST);
        at_frame_end = at_line_end && (eff_line == LINE_LAST);
        close_frame  = at_frame_end || din_endofpacket;
        err_beat     = in_frame && (restart || (at_frame_end != din_endofpacket));
        out_sop      = (eff_pix == '0) && (eff_line == LINE_W'(eff_par));
        out_eop      = din_endofpacket ||
                       (at_line_end && (eff_line == (eff_par ? LINE_LAST : LINE_EVEN_LAST)));
        pix_nxt      = at_line_end ? '0 : eff_pix + PIX_W'(1);
        line_nxt     = at_line_end ? eff_line + LINE_W'(1) : eff_line;
    end

    // Next-state for the frame tracker and the output stage.
    always_comb begin
        // NOTE: every variable gets its hold value first so no path infers a latch.
        state_d      = state_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        parity_d     = parity_q;
        frame_err_d  = accept && err_beat;
        dout_data_d  = dout_data_q;
        dout_valid_d = dout_valid_q;
        dout_sop_d   = dout_sop_q;
        dout_eop_d   = dout_eop_q;
        field_par_d  = field_par_q;

        if (accept && in_frame) begin
            if (close_frame) begin
                state_d    = WAIT_SOP;
                pix_cnt_d  = '0;
                line_cnt_d = '0;
                parity_d   = ~eff_par;
            end else begin
                state_d    = (line_nxt[0] == eff_par) ? KEEP : DROP;
                pix_cnt_d  = pix_nxt;
                line_cnt_d = line_nxt;
                parity_d   = eff_par;
            end
        end

        if (accept && keep_beat) begin
            dout_valid_d = 1'b1;
            dout_data_d  = din_data;
            dout_sop_d   = out_sop;
            dout_eop_d   = out_eop;
            field_par_d  = eff_par;
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    // Frame tracker: state, position counters, field parity and the error pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_SOP;
            pix_cnt_q   <= '0;
            line_cnt_q  <= '0;
            parity_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q     <= state_d;
            pix_cnt_q   <= pix_cnt_d;
            line_cnt_q  <= line_cnt_d;
            parity_q    <= parity_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Single output register stage; holds while the sink downstream stalls.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dout_data_q  <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            field_par_q  <= 1'b0;
        end else begin
            dout_data_q  <= dout_data_d;
            dout_valid_q <= dout_valid_d;
            dout_sop_q   <= dout_sop_d;
            dout_eop_q   <= dout_eop_d;
            field_par_q  <= field_par_d;
        end
    end

    assign dout_data          = dout_data_q;
    assign dout_valid         = dout_valid_q;
    assign dout_startofpacket = dout_sop_q;
    assign dout_endofpacket   = dout_eop_q;
    assign field_parity       = field_par_q;
    assign frame_err          = frame_err_q;

endmodule
